mix_sequencer: RTL
==================

// Module: mix_sequencer
// PURPOSE
//  Sample-rate controller for the note mixing path. On each sample tick it snapshots
//  the 13 per-note square-wave bits, gated by a channel-enable mask, and scans them
//  one per clock into an accumulator. It saturates the sum to the output range and
//  hands the sample to the downstream PWM/DAC stage over a valid/ready handshake.
//  Sits between the per-note oscillators and the audio output stage.
// PARAMETERS
//  NUM_CH   13   number of note channels scanned per sample
//  OUT_W    8    output sample width (bits)
//  AMP      16   unsigned amount added per active, enabled note
//  MAX_VAL  255  saturation ceiling; must be < 2**OUT_W
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous reset, active-high
//  sample_tick   in   1        1-cycle pulse from sample-rate divider; starts a mix
//  note          in   NUM_CH   per-note square-wave bits (bit i = channel i)
//  ch_mask       in   NUM_CH   channel enable; 0 mutes channel i
//  sample        out  OUT_W    mixed, saturated sample (registered)
//  sample_valid  out  1        sample holds a new result not yet accepted
//  sample_ready  in   1        downstream accepts sample when valid && ready
//  busy          out  1        high in SCAN, SAT, HOLD
//  overrun       out  1        1-cycle pulse: sample_tick dropped
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). All state updates on posedge clk.
//  - Reset values: state=IDLE, sample=0, sample_valid=0, busy=0, overrun=0, acc=0, idx=0.
//  - Reset during any state aborts the mix; the partial accumulation is discarded and
//    no sample_valid is issued.
//  - acc width ACC_W = $clog2(NUM_CH*AMP+1); idx width $clog2(NUM_CH). Unsigned math only.
//  - FSM:
//    IDLE: on sample_tick, note_q <= note & ch_mask, acc <= 0, idx <= 0, go to SCAN.
//    SCAN: acc <= acc + (note_q[idx] ? AMP : 0); idx++. After the add at idx==NUM_CH-1,
//          go to SAT. Takes exactly NUM_CH cycles. note/ch_mask changes are ignored here.
//    SAT:  sample <= (acc > MAX_VAL) ? MAX_VAL : acc[OUT_W-1:0]; sample_valid <= 1; go to HOLD.
//    HOLD: hold sample and sample_valid until sample_valid && sample_ready.
//          If sample_tick arrives in the same cycle, capture new snapshot -> SCAN, else -> IDLE.
//          sample_valid drops on the cycle after acceptance.
//  - Latency: tick accepted in cycle T -> sample_valid high in cycle T+NUM_CH+2 (15 at default).
//  - sample retains its last value when sample_valid=0; it changes only in SAT.
//  - sample_tick in SCAN or SAT, or in HOLD without acceptance, is dropped.
//    overrun pulses in the following cycle; the in-flight or held sample is unaffected.
//  - sample_valid never deasserts without acceptance, except on reset.
// CONFIGURATION
//  MIX_OVR_CNT_EN defined: adds output ovr_count [7:0], which counts overrun pulses and
//    saturates at 255. Reset value 0; cleared only by rst.
//  MIX_OVR_CNT_EN undefined: no ovr_count port and no counter logic.
//    The overrun pulse is present in both builds.
// TESTING
//  1. Hold rst for 2 cycles with random inputs -> sample=0, sample_valid=0, busy=0, overrun=0.
//  2. note=13'h0007, ch_mask=13'h1FFF, ready=1, tick at T -> valid at T+15, sample=48,
//     accepted, back to IDLE at T+16.
//  3. AMP=20, note=13'h1FFF, mask all ones -> sum 260, sample=255.
//     Also AMP=19 -> 247 exactly, no saturation.
//  4. note=13'h1FFF, ch_mask=13'h0001 -> sample=16.
//     Change note to 0 mid-SCAN -> result still 16.
//  5. ready=0 after valid; tick in HOLD -> overrun pulse, sample/valid unchanged,
//     ovr_count=1 (macro on). Then ready=1 with tick in the same cycle -> new mix starts,
//     no overrun.
//  6. rst at 5th SCAN cycle -> valid never rises; next tick yields the correct fresh sample.

Source files
------------

// File: rtl/mix_sequencer.sv
// mix_sequencer: per-sample note mixer. On sample_tick it snapshots
// note & ch_mask, scans one channel per clock into an accumulator,
// saturates to MAX_VAL and offers the result on a valid/ready port.
// Ports: clk, rst (sync, active-high), sample_tick, note, ch_mask in;
// sample, sample_valid out; sample_ready in; busy, overrun out.
// Build option MIX_OVR_CNT_EN adds ovr_count[7:0] (saturating count
// of overrun pulses).
module mix_sequencer #(
    parameter int NUM_CH  = 13,
    parameter int OUT_W   = 8,
    parameter int AMP     = 16,
    parameter int MAX_VAL = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [NUM_CH-1:0] note,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [OUT_W-1:0]  sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              overrun
`ifdef MIX_OVR_CNT_EN
    ,
    output logic [7:0]        ovr_count
`endif
);

    localparam int ACC_W = $clog2(NUM_CH * AMP + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [ACC_W-1:0] AMP_A = ACC_W'(AMP);
    localparam logic [EXT_W-1:0] MAX_E = EXT_W'(MAX_VAL);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SAT,
        HOLD
    } state_t;

    state_t            state, state_d;
    logic [NUM_CH-1:0] note_q, note_d;
    logic [ACC_W-1:0]  acc, acc_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [OUT_W-1:0]  sample_d;
    logic              valid_d;
    logic              drop;
    logic [EXT_W-1:0]  acc_ext;

    // Widened copy so the ceiling compare and output slice stay
    // in range whatever ACC_W ends up being relative to OUT_W.
    assign acc_ext = EXT_W'(acc);
    assign busy    = (state != IDLE);

    always_comb begin
        state_d  = state;
        note_d   = note_q;
        acc_d    = acc;
        idx_d    = idx;
        sample_d = sample;
        valid_d  = sample_valid;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_tick) begin
                    note_d  = note & ch_mask;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = acc + (note_q[idx] ? AMP_A : '0);
                idx_d = idx + IDX_W'(1);
                if (idx == LAST) state_d = SAT;
                drop = sample_tick;
            end
            SAT: begin
                sample_d = (acc_ext > MAX_E) ? MAX_E[OUT_W-1:0]
                                             : acc_ext[OUT_W-1:0];
                valid_d  = 1'b1;
                state_d  = HOLD;
                drop     = sample_tick;
            end
            HOLD: begin
                if (sample_valid && sample_ready) begin
                    valid_d = 1'b0;
                    // A tick coinciding with acceptance starts the
                    // next mix immediately instead of being dropped.
                    if (sample_tick) begin
                        note_d  = note & ch_mask;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    drop = sample_tick;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            note_q       <= '0;
            acc          <= '0;
            idx          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_d;
            note_q       <= note_d;
            acc          <= acc_d;
            idx          <= idx_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            overrun      <= drop;
        end
    end

`ifdef MIX_OVR_CNT_EN
    // Bumped on the same edge that raises overrun, so the count
    // already includes a pulse while it is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_count <= '0;
        end else if (drop && ovr_count != 8'hFF) begin
            ovr_count <= ovr_count + 8'd1;
        end
    end
`endif

endmodule
